// File: rtl/perceptron.sv
// Single-neuron datapath: y = relu_sat(sum(x[i]*w[i]) + b), two registered stages.
// Products and bias are registered first; the adder tree and activation feed the y register.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module perceptron #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] x [N],
    input  logic signed [DATA_WIDTH-1:0] w [N],
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] y
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(N) + 1;
    localparam int LEAVES = 2 ** $clog2(N);
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (DATA_WIDTH - 1)) - 1);

    logic signed [PROD_W-1:0]     p_q [N];
    logic signed [DATA_WIDTH-1:0] b_q;

    logic signed [ACC_W-1:0]      tree [2*LEAVES-1];
    logic signed [ACC_W-1:0]      s;
    logic signed [DATA_WIDTH-1:0] y_next;

    // Stage 1: full-width products, bias carried alongside.
    always_ff @(posedge clk) begin
        // NOTE: rst_n is a synchronous active-high reset despite its name.
        if (rst_n) begin
            // NOTE: the product array is only N registers, so it is cleared
            // on reset to keep stale sums from reaching y after release.
            for (int i = 0; i < N; i++) begin
                p_q[i] <= '0;
            end
            b_q <= '0;
        end else begin
            // NOTE: non-blocking assignments for all clocked state.
            for (int i = 0; i < N; i++) begin
                p_q[i] <= PROD_W'(x[i]) * PROD_W'(w[i]);
            end
            b_q <= b;
        end
    end

    // Stage 2: balanced adder tree in heap layout (root at 0), then ReLU + saturation.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        for (int i = 0; i < 2*LEAVES-1; i++) begin
            tree[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            tree[LEAVES-1+i] = ACC_W'(p_q[i]);
        end
        for (int k = LEAVES - 2; k >= 0; k--) begin
            tree[k] = tree[2*k+1] + tree[2*k+2];
        end

        s = tree[0] + ACC_W'(b_q);

        y_next = s[DATA_WIDTH-1:0];
        if (s < 0) begin
            y_next = '0;
        end else if (s > Y_MAX) begin
            y_next = Y_MAX[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            y <= '0;
        end else begin
            y <= y_next;
        end
    end

endmodule

// File: tb/tb_perceptron.sv
// Directed bench for perceptron: vector table with hand-computed results,
// plus reset, streaming and mid-stream reset sequences.
module tb_perceptron;

    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [N-1:0][DW-1:0] xv;
        logic [N-1:0][DW-1:0] wv;
        logic [DW-1:0]        bv;
        logic [DW-1:0]        exp;
    } vec_t;

    logic                 clk;
    logic                 rst_n;
    logic signed [DW-1:0] x [N];
    logic signed [DW-1:0] w [N];
    logic signed [DW-1:0] b;
    logic signed [DW-1:0] y;

    int n_tests;
    int n_fail;

    perceptron #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .w     (w),
        .b     (b),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int x0, x1, x2, x3,
                                input int w0, w1, w2, w3,
                                input int bb, input int e);
        vec_t v;
        v.xv[0] = DW'(x0); v.xv[1] = DW'(x1); v.xv[2] = DW'(x2); v.xv[3] = DW'(x3);
        v.wv[0] = DW'(w0); v.wv[1] = DW'(w1); v.wv[2] = DW'(w2); v.wv[3] = DW'(w3);
        v.bv  = DW'(bb);
        v.exp = DW'(e);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        for (int i = 0; i < N; i++) begin
            x[i] = $signed(v.xv[i]);
            w[i] = $signed(v.wv[i]);
        end
        b = $signed(v.bv);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: y=%0d expected=%0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [14];
    vec_t s10, s0, s18, s5;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        tbl[0]  = mk(1, 2, 3, 4,        2, -1, 3, 1,        5,    18);
        tbl[1]  = mk(0, 0, 0, 0,        0, 0, 0, 0,         0,    0);
        tbl[2]  = mk(1, 2, 3, 4,        -1, -1, -1, -1,     0,    0);
        tbl[3]  = mk(0, 0, 0, 0,        3, 3, 3, 3,         -5,   0);
        tbl[4]  = mk(0, 0, 0, 0,        3, 3, 3, 3,         5,    5);
        tbl[5]  = mk(1, 1, 1, 1,        1, 1, 1, 1,         -4,   0);
        tbl[6]  = mk(127, 127, 127, 127, 127, 127, 127, 127, 127, 127);
        tbl[7]  = mk(-128, -128, -128, -128, -128, -128, -128, -128, 0, 127);
        tbl[8]  = mk(-128, -128, -128, -128, 127, 127, 127, 127, -128, 0);
        tbl[9]  = mk(127, 0, 0, 0,      1, 0, 0, 0,         0,    127);
        tbl[10] = mk(64, 0, 0, 0,       2, 0, 0, 0,         0,    127);
        tbl[11] = mk(63, 0, 0, 0,       2, 0, 0, 0,         0,    126);
        tbl[12] = mk(50, -30, 0, 0,     2, 3, 0, 0,         20,   30);
        tbl[13] = mk(16, 0, 0, 0,       16, 0, 0, 0,        -127, 127);

        s10 = mk(1, 2, 3, 4, 1, 1, 1, 1, 0, 10);
        s0  = mk(1, 2, 3, 4, -1, -1, -1, -1, 0, 0);
        s18 = tbl[0];
        s5  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);

        // Reset held for two edges with live inputs.
        rst_n = 1'b1;
        drive(s10);
        edge_sample();
        check("reset_hold_0", y, 8'd0);
        edge_sample();
        check("reset_hold_1", y, 8'd0);
        @(negedge clk);
        rst_n = 1'b0;
        edge_sample();
        check("first_edge_after_release", y, 8'd0);
        edge_sample();
        check("release_result", y, s10.exp);

        // Table: hold each vector for two edges, then compare.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            edge_sample();
            edge_sample();
            check($sformatf("vec%0d", i), y, tbl[i].exp);
        end

        // Streaming: 10, 0, 18 on consecutive cycles.
        @(negedge clk);
        drive(s5);
        edge_sample();
        edge_sample();
        @(negedge clk);
        drive(s10);
        edge_sample();
        check("stream_pre", y, 8'd5);
        @(negedge clk);
        drive(s0);
        edge_sample();
        check("stream_0", y, 8'd10);
        @(negedge clk);
        drive(s18);
        edge_sample();
        check("stream_1", y, 8'd0);
        @(negedge clk);
        drive(s10);
        edge_sample();
        check("stream_2", y, 8'd18);

        // Mid-stream reset: in-flight 10 and 18 must be discarded.
        @(negedge clk);
        drive(s18);
        rst_n = 1'b1;
        edge_sample();
        check("midreset_edge", y, 8'd0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(s5);
        edge_sample();
        check("midreset_no_stale", y, 8'd0);
        @(negedge clk);
        drive(s0);
        edge_sample();
        check("midreset_post", y, 8'd5);
        edge_sample();
        check("midreset_post_next", y, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/perceptron.md
# perceptron

Single-neuron compute block for the NPU datapath. Each cycle it takes an N-element signed input vector, an N-element signed weight vector and a signed bias. It computes the dot product plus bias, applies a ReLU activation with saturation, and presents the result on a registered output after a fixed two-cycle latency. It is fully pipelined, with one new input set accepted every cycle, and sits between the operand buffers and the layer output buffer.

## Interface
- N, default 4: vector dimensionality (N ≥ 1).
- DATA_WIDTH, default 8: width of every data operand and of the result, taken from the shared width header (`DATA_WIDTH`).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset. Despite the port name, it is synchronous and active-high: sampled on the rising edge of clk, and asserts when 1.
- x, input, DATA_WIDTH signed × N (unpacked array x[N]): input activations.
- w, input, DATA_WIDTH signed × N (unpacked array w[N]): weights.
- b, input, DATA_WIDTH signed: bias.
- y, output, DATA_WIDTH signed: activated result, registered.

## Operation
- All operands are two's-complement signed integers (no fractional scaling).
- Stage 1 (registered):
  - Products p[i] = x[i]·w[i] at full 2·DATA_WIDTH width, with no truncation.
  - b is registered alongside the products.
- Stage 2 (registered into y):
  - Accumulator width is 2·DATA_WIDTH + $clog2(N) + 1, which is enough to never overflow.
  - Sum s = Σ p[i] + sign-extended b.
  - ReLU: if s < 0, y = 0.
  - Saturation: if s > 2^(DATA_WIDTH−1)−1, y = 2^(DATA_WIDTH−1)−1 (127 for 8-bit).
  - Otherwise y = s[DATA_WIDTH−1:0].
- y is therefore always in [0, 2^(DATA_WIDTH−1)−1] and is never negative.
- The block has no handshake and no valid signals. Inputs are sampled every rising edge and each input set flows independently through the pipeline.
- Sum order is an implementation choice (a balanced adder tree is recommended). The result must be bit-exact with the formula above for all inputs.

## Timing
- Reset: when rst_n = 1 at a rising edge, all stage-1 registers and y are cleared to 0 on that edge. y reads 0 while reset is held.
- Latency: inputs sampled at rising edge k appear on y after rising edge k+1, i.e. 2 edges.
- Throughput: 1 input set per cycle. Back-to-back distinct inputs produce back-to-back distinct outputs in order.
- First edge after reset deassertion: stage 1 captures the current inputs, and y remains 0 from reset until the following edge.
- Reset mid-stream: in-flight data is discarded and y = 0 on the next edge. No stale result may appear after reset is released.
- There is no combinational path from any input to y.

## Test plan
- Reset: hold rst_n = 1 for 2 cycles with x = {1,2,3,4}, w = {1,1,1,1}, b = 0 → y = 0 throughout. Release reset → y = 10 two edges later.
- Basic dot product: x = {1,2,3,4}, w = {2,−1,3,1}, b = 5 → y = 2−2+9+4+5 = 18 after 2 edges. All-zero x, w, b → y = 0.
- ReLU and bias:
  - x = {1,2,3,4}, w = {−1,−1,−1,−1}, b = 0 → y = 0.
  - x = {0,0,0,0}, b = −5 → y = 0.
  - x = {0,0,0,0}, b = 5 → y = 5.
  - x = {1,1,1,1}, w = {1,1,1,1}, b = −4 → y = 0 (exact zero boundary).
- Saturation and extremes:
  - x = all 127, w = all 127, b = 127 → y = 127.
  - x = all −128, w = all −128, b = 0 (sum 65536, no internal overflow) → y = 127.
  - x = all −128, w = all 127, b = −128 → y = 0.
  - x = {127,0,0,0}, w = {1,0,0,0}, b = 0 → y = 127 exactly, with no saturation flag effect.
- Streaming: apply three input sets on consecutive cycles with expected results 10, 0 and 18 → y shows 10, 0, 18 on consecutive cycles starting 2 edges after the first set.
- Mid-stream reset: during the streaming test, assert rst_n for 1 edge → y = 0 on that edge. Outputs after release reflect only post-reset inputs.
